// File: rtl/ate_pkg.sv
// Shared image geometry and scheduler FSM encoding for the ATE block scheduler.
package ate_pkg;
  localparam int ATE_IMG_W = 48;
  localparam int ATE_IMG_H = 32;
  localparam int ATE_BLK   = 8;

  function automatic int ate_bpr(input int img_w, input int blk);
    return img_w / blk;
  endfunction

  localparam int ATE_BPR = ate_bpr(ATE_IMG_W, ATE_BLK);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;
endpackage

// File: rtl/ate_tag_fifo.sv
// Two-entry output buffer holding pixel data plus block tags; push and pop may coincide.
module ate_tag_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
endmodule

// File: rtl/ate_blk_sched.sv
// Reads an image ROM in block order (blocks row-major, pixels row-major within a block)
// and streams pixels with block tags over a valid/ready handshake; border blocks read as zero.
module ate_blk_sched
  import ate_pkg::*;
#(
  parameter int IMG_W = ATE_IMG_W,
  parameter int IMG_H = ATE_IMG_H,
  parameter int BLK   = ATE_BLK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        rom_rd,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_q,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_data,
  output logic        blk_first,
  output logic        blk_last,
  output logic        blk_border,
  output logic [4:0]  blk_idx,
  output logic        busy,
  output logic        done
);
  localparam int BPR = ate_bpr(IMG_W, BLK);
  localparam int BPC = IMG_H / BLK;
  localparam int PW  = $clog2(BLK);
  localparam int CW  = $clog2(BPR);
  localparam int RW  = $clog2(BPC);
  localparam int TW  = 16;
  // Address deltas when a pixel row, a block, or a block row wraps.
  localparam int ROW_STEP = IMG_W - BLK + 1;
  localparam int BLK_STEP = 1 - (BLK - 1) * IMG_W;

  sched_state_t  state_reg;
  logic [PW-1:0] pcol_reg, prow_reg;
  logic [CW-1:0] bcol_reg;
  logic [RW-1:0] brow_reg;
  logic [10:0]   addr_reg;
  logic [4:0]    idx_reg;
  logic          inflight_reg;
  logic [7:0]    tag_reg;
  logic          busy_reg, done_reg;

  logic          pop, last_pix, cur_first, cur_last, cur_border;
  logic [2:0]    occ;
  logic [1:0]    fifo_count;
  logic [TW-1:0] fifo_head, push_data;

  assign cur_first  = (pcol_reg == '0) && (prow_reg == '0);
  assign cur_last   = (pcol_reg == PW'(BLK - 1)) && (prow_reg == PW'(BLK - 1));
  assign cur_border = (bcol_reg == '0) || (bcol_reg == CW'(BPR - 1));
  assign last_pix   = cur_last && (bcol_reg == CW'(BPR - 1)) && (brow_reg == RW'(BPC - 1));

  assign pix_valid = (fifo_count != 2'd0);
  assign pop       = pix_valid && pix_ready;
  // Occupancy after this cycle's pop plus the read whose data is on rom_q now.
  assign occ       = {1'b0, fifo_count} + {2'b0, inflight_reg} - {2'b0, pop};
  assign rom_rd    = (state_reg == ST_RUN) && (occ < 3'd2);
  assign rom_addr  = addr_reg;

  assign push_data = {(tag_reg[5] ? 8'h00 : rom_q), tag_reg};

  ate_tag_fifo #(.W(TW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_reg),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign {pix_data, blk_first, blk_last, blk_border, blk_idx} = pix_valid ? fifo_head : '0;
  assign busy = busy_reg;
  assign done = done_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      pcol_reg     <= '0;
      prow_reg     <= '0;
      bcol_reg     <= '0;
      brow_reg     <= '0;
      addr_reg     <= '0;
      idx_reg      <= '0;
      inflight_reg <= 1'b0;
      tag_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg     <= 1'b0;
      inflight_reg <= rom_rd;
      if (rom_rd) begin
        tag_reg <= {cur_first, cur_last, cur_border, idx_reg};
        if (pcol_reg != PW'(BLK - 1)) begin
          pcol_reg <= pcol_reg + 1'b1;
          addr_reg <= addr_reg + 11'd1;
        end else begin
          pcol_reg <= '0;
          if (prow_reg != PW'(BLK - 1)) begin
            prow_reg <= prow_reg + 1'b1;
            addr_reg <= addr_reg + 11'(ROW_STEP);
          end else begin
            prow_reg <= '0;
            if (bcol_reg != CW'(BPR - 1)) begin
              bcol_reg <= bcol_reg + 1'b1;
              idx_reg  <= idx_reg + 5'd1;
              addr_reg <= addr_reg + 11'(BLK_STEP);
            end else begin
              bcol_reg <= '0;
              if (brow_reg != RW'(BPC - 1)) begin
                brow_reg <= brow_reg + 1'b1;
                idx_reg  <= idx_reg + 5'd1;
                addr_reg <= addr_reg + 11'd1;
              end else begin
                brow_reg <= '0;
                idx_reg  <= '0;
                addr_reg <= '0;
              end
            end
          end
        end
      end
      case (state_reg)
        ST_IDLE: begin
          // busy stays up through the done cycle, which also masks a coincident start.
          if (done_reg) busy_reg <= 1'b0;
          if (start && !busy_reg) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (rom_rd && last_pix) state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!inflight_reg && fifo_count == 2'd1 && pop) begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/ate_blk_sched.md
ATE_BLK_SCHED -- requirements
Module: ate_blk_sched

Interface
REQ-001 SHALL have parameters: IMG_W, default 48, image width in pixels; IMG_H, default 32, image height in pixels; BLK, default 8, block edge in pixels.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic SHALL be rising-edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a one-cycle pulse that begins a frame.
REQ-005 SHALL have port rom_rd, output, 1, image ROM read strobe.
REQ-006 SHALL have port rom_addr, output, 11, raster address (row*IMG_W+col).
REQ-007 SHALL have port rom_q, input, 8, ROM data, valid exactly 1 cycle after rom_rd.
REQ-008 SHALL have port pix_valid, output, 1, pixel offered to the engine.
REQ-009 SHALL have port pix_ready, input, 1, engine accepts the pixel.
REQ-010 SHALL have port pix_data, output, 8, pixel value.
REQ-011 SHALL have ports blk_first, blk_last and blk_border, output, 1 each: pixel 0 of a block, pixel 63 of a block, and block in border column, all qualified by pix_valid.
REQ-012 SHALL have port blk_idx, output, 5, block number 0..23, qualified by pix_valid.
REQ-013 SHALL have ports busy and done, output, 1 each: frame in progress, and a one-cycle pulse after the last pixel is accepted.

Function
REQ-014 SHALL emit pixels in block order: blocks row-major (blk_idx = brow*6 + bcol); within a block, pixels row-major, so p = prow*8 + pcol.
REQ-015 SHALL generate rom_addr = (brow*8 + prow)*IMG_W + bcol*8 + pcol using nested counters pcol, prow, bcol, brow; no divider or multiplier beyond constant shifts/adds.
REQ-016 SHALL flag blk_border when bcol==0 or bcol==IMG_W/BLK-1 (blocks 0, 5, 6, 11, 12, 17, 18, 23 at defaults).
REQ-017 SHALL still read the ROM for border pixels but force pix_data to 0x00 for them, using a border tag pipelined alongside the read.
REQ-018 SHALL use FSM states IDLE, RUN and DRAIN. IDLE goes to RUN on start. RUN goes to DRAIN after the read for the final pixel (addr 1535) is issued. DRAIN goes to IDLE when the output buffer is empty and the last pixel is accepted, and done SHALL pulse on that transition.
REQ-019 SHALL buffer ROM returns in a 2-entry FIFO (8-bit data plus first/last/border/idx tags); rom_rd SHALL assert only when FIFO occupancy plus in-flight reads < 2.
REQ-020 SHALL, with pix_ready held high, sustain one pixel per cycle, with the first pix_valid 2 cycles after start.
REQ-021 SHALL hold pix_valid and all qualified outputs stable until pix_ready is sampled high; pix_valid SHALL NOT drop without a handshake.
REQ-022 SHALL allow a FIFO push and pop in the same cycle, with occupancy unchanged.
REQ-023 SHALL ignore start while busy; start coincident with done SHALL be ignored.
REQ-024 SHALL wrap all counters to 0 after the final pixel so the next frame restarts at block 0, pixel 0.
REQ-025 SHALL hold busy high from the cycle after start through the done pulse inclusive.

Reset
REQ-026 SHALL, on reset low, asynchronously clear FSM to IDLE, all counters, FIFO occupancy and the in-flight flag.
REQ-027 SHALL, in reset, drive rom_rd, pix_valid, blk_first, blk_last, blk_border, busy and done to 0, and rom_addr, pix_data and blk_idx to 0.
REQ-028 SHALL, on reset mid-frame, discard buffered pixels; after release, no output SHALL toggle until the next start.

Structure
REQ-029 SHALL take ATE_IMG_W, ATE_IMG_H, ATE_BLK, the block-per-row count and the FSM state encoding from the shared package ate_pkg.
REQ-030 SHALL instantiate one sub-module, ate_tag_fifo (2-entry, parameterised width), for the output buffer.

Verification
REQ-031 Reset, then start with pix_ready=1 -> exactly 1536 handshakes, pix_valid first at cycle 2, done at handshake 1536+1, busy low after.
REQ-032 ROM data = addr[7:0] -> block 1 pixel 0 gives rom_addr 8, pix_data 0x08; block 7 pixel 9 gives addr 441; every border-block pixel is 0x00.
REQ-033 pix_ready toggles 1,0,0,1 repeating -> no pixel lost or duplicated, outputs stable while stalled, FIFO never exceeds 2.
REQ-034 blk_first/blk_last observed -> exactly 24 each, at p=0 and p=63, with blk_idx incrementing 0..23; blk_border asserted for 8 blocks.
REQ-035 Reset asserted at handshake 700, released, then start -> the stream restarts at blk_idx 0, addr 0, with no stale pixel emitted.
REQ-036 start pulsed at cycle 100 mid-frame and again coincident with done -> both ignored, total handshakes 1536.
